// File: rtl/res_pack.sv
// res_pack: thresholds a 128x128 byte result map into 1024 packed 16-bit words.
// Define RES_PACK_CNT_EN to add a ones_cnt output counting the 1 pixels of a run.
module res_pack #(
   parameter logic [7:0] THRESH = 8'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        res_rd,
   output logic [13:0] res_addr,
   input  logic [7:0]  res_di,
   output logic        sti_wr,
   output logic [9:0]  sti_addr,
   output logic [15:0] sti_do
`ifdef RES_PACK_CNT_EN
   ,
   output logic [14:0] ones_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   localparam logic [13:0] LAST_ADDR = 14'h3FFF;

   state_t      state;
   state_t      next_state;
   logic        launch;
   logic        advance;
   logic        sample;
   logic        pixel;
   logic [14:0] acc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // RUN hands over to FLUSH as the final address goes out; FLUSH then waits
   // one cycle for that address's data before the closing write.
   always_comb begin
      next_state = state;
      launch     = 1'b0;
      advance    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = RUN;
               launch     = 1'b1;
            end
         end
         RUN: begin
            busy    = 1'b1;
            advance = 1'b1;
            if (res_addr == LAST_ADDR - 14'd1) next_state = FLUSH;
         end
         FLUSH: begin
            busy = 1'b1;
            if (!res_rd) next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Read data returns in the cycle after its address, so the sample taken at an
   // edge belongs to the address still held in res_addr at that edge.
   assign sample = res_rd;
   assign pixel  = (res_di > THRESH);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_rd   <= 1'b0;
         res_addr <= 14'd0;
      end else if (launch) begin
         res_rd   <= 1'b1;
         res_addr <= 14'd0;
      end else if (advance) begin
         res_addr <= res_addr + 14'd1;
      end else if (state == FLUSH) begin
         res_rd <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc      <= 15'd0;
         sti_wr   <= 1'b0;
         sti_addr <= 10'd0;
         sti_do   <= 16'd0;
      end else begin
         sti_wr <= 1'b0;
         if (sample) begin
            if (res_addr[3:0] == 4'hF) begin
               sti_wr   <= 1'b1;
               sti_addr <= res_addr[13:4];
               sti_do   <= {pixel, acc};
            end else begin
               acc[res_addr[3:0]] <= pixel;
            end
         end
      end
   end

`ifdef RES_PACK_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                ones_cnt <= 15'd0;
      else if (launch)          ones_cnt <= 15'd0;
      else if (sample && pixel) ones_cnt <= ones_cnt + 15'd1;
   end
`endif

endmodule
